// File: rtl/store_buffer_if.sv
// Store buffer bus: execute-stage allocation, commit retire, D-cache drain
// and load-forwarding lookup, grouped for the store_buffer port list.
interface store_buffer_if #(
    parameter int DEPTH = 8
);
    logic                       alloc_en;
    logic [31:0]                alloc_addr;
    logic [31:0]                alloc_data;
    logic [3:0]                 alloc_be;
    logic                       write1;
    logic                       write2;
    logic                       flush;
    logic                       dc_req;
    logic [31:0]                dc_addr;
    logic [31:0]                dc_data;
    logic [3:0]                 dc_be;
    logic                       dc_ack;
    logic [31:0]                ld_addr;
    logic                       fwd_hit;
    logic [31:0]                fwd_data;
    logic [3:0]                 fwd_be;
    logic                       full;
    logic                       empty;
    logic [$clog2(DEPTH):0]     count;

    modport master (
        output alloc_en, alloc_addr, alloc_data, alloc_be,
        output write1, write2, flush, dc_ack, ld_addr,
        input  dc_req, dc_addr, dc_data, dc_be,
        input  fwd_hit, fwd_data, fwd_be, full, empty, count
    );

    modport slave (
        input  alloc_en, alloc_addr, alloc_data, alloc_be,
        input  write1, write2, flush, dc_ack, ld_addr,
        output dc_req, dc_addr, dc_data, dc_be,
        output fwd_hit, fwd_data, fwd_be, full, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of speculative and committed stores with
// head/cmt/tail pointers, in-order D-cache drain and youngest-match forwarding.
module store_buffer #(
    parameter int DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    store_buffer_if.slave   sb
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    ptr_t        head_r, cmt_r, tail_r;
    logic [31:0] addr_mem_r [DEPTH];
    logic [31:0] data_mem_r [DEPTH];
    logic [3:0]  be_mem_r   [DEPTH];

    ptr_t        count_s, uncmt_s, ncommit_s, commit_adv_s;
    ptr_t        head_next_s, cmt_next_s, tail_next_s;
    logic        full_s, empty_s, dc_req_s, alloc_ok_s, drain_s;
    logic        fwd_hit_s, match_s;
    logic [31:0] fwd_data_s;
    logic [3:0]  fwd_be_s;
    logic [AW-1:0] idx_s;
    logic        unused_ld_s;

    // Pointer differences wrap modulo 2*DEPTH, so the wrap bit separates full from empty
    assign count_s  = tail_r - head_r;
    assign uncmt_s  = tail_r - cmt_r;
    assign full_s   = (count_s == ptr_t'(DEPTH));
    assign empty_s  = (count_s == ptr_t'(0));
    assign dc_req_s = (head_r != cmt_r);
    assign unused_ld_s = ^sb.ld_addr[1:0];

    // Next-state for the three pointers: commit clamp, drain, flush-over-alloc
    always_comb begin
        ncommit_s    = ptr_t'({1'b0, sb.write1}) + ptr_t'({1'b0, sb.write2});
        commit_adv_s = (ncommit_s > uncmt_s) ? uncmt_s : ncommit_s;
        cmt_next_s   = cmt_r + commit_adv_s;
        alloc_ok_s   = sb.alloc_en & ~full_s & ~sb.flush;
        drain_s      = dc_req_s & sb.dc_ack;
        if (drain_s) begin
            head_next_s = head_r + ptr_t'(1);
        end else begin
            head_next_s = head_r;
        end
        if (sb.flush) begin
            tail_next_s = cmt_next_s;
        end else if (alloc_ok_s) begin
            tail_next_s = tail_r + ptr_t'(1);
        end else begin
            tail_next_s = tail_r;
        end
    end

    // Pointer registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= '0;
            cmt_r  <= '0;
            tail_r <= '0;
        end else begin
            head_r <= head_next_s;
            cmt_r  <= cmt_next_s;
            tail_r <= tail_next_s;
        end
    end

    // Entry storage; contents are don't-care outside [head, tail) so no reset
    always_ff @(posedge clk) begin
        if (alloc_ok_s) begin
            addr_mem_r[tail_r[AW-1:0]] <= sb.alloc_addr;
            data_mem_r[tail_r[AW-1:0]] <= sb.alloc_data;
            be_mem_r[tail_r[AW-1:0]]   <= sb.alloc_be;
        end
    end

    // Forwarding scan oldest-to-youngest so the last match (youngest) wins
    always_comb begin
        fwd_hit_s  = 1'b0;
        fwd_data_s = 32'h0000_0000;
        fwd_be_s   = 4'h0;
        idx_s      = '0;
        match_s    = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s      = head_r[AW-1:0] + AW'(i);
            match_s    = (ptr_t'(i) < count_s) &&
                         (addr_mem_r[idx_s][31:2] == sb.ld_addr[31:2]);
            fwd_hit_s  = fwd_hit_s | match_s;
            fwd_data_s = match_s ? data_mem_r[idx_s] : fwd_data_s;
            fwd_be_s   = match_s ? be_mem_r[idx_s]   : fwd_be_s;
        end
    end

    assign sb.count    = count_s;
    assign sb.full     = full_s;
    assign sb.empty    = empty_s;
    assign sb.dc_req   = dc_req_s;
    assign sb.dc_addr  = addr_mem_r[head_r[AW-1:0]];
    assign sb.dc_data  = data_mem_r[head_r[AW-1:0]];
    assign sb.dc_be    = be_mem_r[head_r[AW-1:0]];
    assign sb.fwd_hit  = fwd_hit_s;
    assign sb.fwd_data = fwd_data_s;
    assign sb.fwd_be   = fwd_be_s;
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_store_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    store_buffer_if #(.DEPTH(DEPTH)) bus ();
    store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sb(bus));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    ent_t        mq[$];
    int          ncmt = 0;
    logic [31:0] accepted[$];
    logic [31:0] drained[$];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: queue of entries, the oldest ncmt of which are committed
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            ncmt = 0;
            accepted.delete();
            drained.delete();
        end else begin
            int   n;
            bit   full_m, req_m;
            ent_t e;
            full_m = (mq.size() == DEPTH);
            req_m  = (ncmt > 0);
            n = int'(bus.write1) + int'(bus.write2);
            if (n > mq.size() - ncmt) n = mq.size() - ncmt;
            ncmt += n;
            if (req_m && bus.dc_ack) begin
                drained.push_back(bus.dc_data);
                void'(mq.pop_front());
                ncmt--;
            end
            if (bus.flush) begin
                while (mq.size() > ncmt) void'(mq.pop_back());
            end else if (bus.alloc_en && !full_m) begin
                e.addr = bus.alloc_addr;
                e.data = bus.alloc_data;
                e.be   = bus.alloc_be;
                mq.push_back(e);
                accepted.push_back(bus.alloc_data);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            bit          hit_m;
            logic [31:0] fd_m;
            logic [3:0]  fb_m;
            hit_m = 1'b0;
            fd_m  = 32'h0;
            fb_m  = 4'h0;
            for (int j = mq.size() - 1; j >= 0 && !hit_m; j--) begin
                if (mq[j].addr[31:2] == bus.ld_addr[31:2]) begin
                    hit_m = 1'b1;
                    fd_m  = mq[j].data;
                    fb_m  = mq[j].be;
                end
            end
            chk("m_count",  32'(bus.count),  32'(mq.size()));
            chk("m_full",   32'(bus.full),   32'(mq.size() == DEPTH));
            chk("m_empty",  32'(bus.empty),  32'(mq.size() == 0));
            chk("m_dc_req", 32'(bus.dc_req), 32'(ncmt > 0));
            if (ncmt > 0) begin
                chk("m_dc_addr", bus.dc_addr,        mq[0].addr);
                chk("m_dc_data", bus.dc_data,        mq[0].data);
                chk("m_dc_be",   32'(bus.dc_be),     32'(mq[0].be));
            end
            chk("m_fwd_hit",  32'(bus.fwd_hit), 32'(hit_m));
            chk("m_fwd_data", bus.fwd_data,     fd_m);
            chk("m_fwd_be",   32'(bus.fwd_be),  32'(fb_m));
        end
    end

    task automatic drive(input logic ae, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic w1, input logic w2,
                         input logic fl, input logic ack);
        bus.alloc_en   = ae;
        bus.alloc_addr = a;
        bus.alloc_data = d;
        bus.alloc_be   = be;
        bus.write1     = w1;
        bus.write2     = w2;
        bus.flush      = fl;
        bus.dc_ack     = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    initial begin
        bus.ld_addr = 32'h0;
        bus.alloc_en = 1'b0; bus.alloc_addr = 32'h0; bus.alloc_data = 32'h0;
        bus.alloc_be = 4'h0; bus.write1 = 1'b0; bus.write2 = 1'b0;
        bus.flush = 1'b0; bus.dc_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count",  32'(bus.count),   32'd0);
        chk("rst_empty",  32'(bus.empty),   32'd1);
        chk("rst_full",   32'(bus.full),    32'd0);
        chk("rst_dc_req", 32'(bus.dc_req),  32'd0);
        chk("rst_fwd",    32'(bus.fwd_hit), 32'd0);
        rst = 1'b0;

        // Three stores, double commit, ack held high: in-order drain
        drive(1'b1, 32'h100, 32'h11, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("first_alloc_count", 32'(bus.count), 32'd1);
        drive(1'b1, 32'h104, 32'h22, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 32'h108, 32'h33, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c3_dc_req_pre", 32'(bus.dc_req), 32'd0);
        chk("c3_count",      32'(bus.count),  32'd3);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("c3_dc_req",  32'(bus.dc_req), 32'd1);
        chk("c3_addr0",   bus.dc_addr,     32'h100);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c3_addr1",   bus.dc_addr,     32'h104);
        chk("c3_data1",   bus.dc_data,     32'h22);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("c3_count_end", 32'(bus.count),  32'd1);
        chk("c3_req_end",   32'(bus.dc_req), 32'd0);

        // Fill to full, dropped 9th, then commit + drain frees one
        do_reset();
        for (int i = 0; i < DEPTH; i++)
            drive(1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_flag",  32'(bus.full),  32'd1);
        chk("full_count", 32'(bus.count), 32'd8);
        drive(1'b1, 32'h340, 32'hFF, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("drop_count", 32'(bus.count), 32'd8);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("free_full",  32'(bus.full),  32'd0);
        chk("free_count", 32'(bus.count), 32'd7);

        // Flush with one commit and a colliding alloc
        do_reset();
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h400 + 32'(4 * i), 32'h40 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h500, 32'h55, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("flush_count", 32'(bus.count),  32'd1);
        chk("flush_req",   32'(bus.dc_req), 32'd1);
        bus.ld_addr = 32'h408;
        #1;
        chk("flush_fwd_gone", 32'(bus.fwd_hit), 32'd0);
        bus.ld_addr = 32'h400;
        #1;
        chk("flush_fwd_kept", 32'(bus.fwd_hit), 32'd1);
        chk("flush_fwd_data", bus.fwd_data,     32'h40);
        bus.ld_addr = 32'h500;
        #1;
        chk("flush_new_drop", 32'(bus.fwd_hit), 32'd0);
        bus.ld_addr = 32'h0;

        // Youngest match wins, no merging
        do_reset();
        drive(1'b1, 32'h200, 32'hAAAA_AAAA, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'h200, 32'hBBBB_BBBB, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.ld_addr = 32'h202;
        #1;
        chk("fwd_hit",  32'(bus.fwd_hit), 32'd1);
        chk("fwd_data", bus.fwd_data,     32'hBBBB_BBBB);
        chk("fwd_be",   32'(bus.fwd_be),  32'd3);
        bus.ld_addr = 32'h0;

        // Mixed traffic across a pointer wrap
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h1000 + 32'(4 * k), 32'(k), 4'hF, k >= 8, 1'b0, 1'b0, k >= 9);
            if (k == 7) chk("wrap_full", 32'(bus.full), 32'd1);
        end
        for (int k = 0; k < 12; k++)
            drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("wrap_empty",   32'(bus.empty),        32'd1);
        chk("wrap_ndrain",  32'(drained.size()),   32'd18);
        chk("wrap_naccept", 32'(accepted.size()),  32'd18);
        if (drained.size() == 18) chk("wrap_d8", drained[8], 32'd10);
        for (int j = 0; j < drained.size() && j < accepted.size(); j++)
            chk("wrap_order", drained[j], accepted[j]);

        // Asynchronous reset mid-drain
        do_reset();
        for (int i = 0; i < 5; i++)
            drive(1'b1, 32'h600 + 32'(4 * i), 32'h60 + 32'(i), 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("ar_req_pre",   32'(bus.dc_req), 32'd1);
        chk("ar_count_pre", 32'(bus.count),  32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_count", 32'(bus.count),  32'd0);
        chk("ar_empty", 32'(bus.empty),  32'd1);
        chk("ar_req",   32'(bus.dc_req), 32'd0);
        rst = 1'b0;
        drive(1'b1, 32'h700, 32'h77, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ar_realloc", 32'(bus.count), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
